// File: rtl/demux_sel_sequencer_if.sv
// Handshake and demux-side signal bundle for demux_sel_sequencer.
// The master drives the stream and control inputs. The slave is the sequencer.
interface demux_sel_sequencer_if;
    logic       start;
    logic       abort;
    logic [3:0] en_mask;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic       y;
    logic [1:0] s;
    logic       y_valid;
    logic       busy;
    logic       frame_done;

    modport master (
        output start, abort, en_mask, in_bit, in_valid,
        input  in_ready, y, s, y_valid, busy, frame_done
    );

    modport slave (
        input  start, abort, en_mask, in_bit, in_valid,
        output in_ready, y, s, y_valid, busy, frame_done
    );
endinterface

// File: rtl/demux_sel_sequencer.sv
// Round-robin select sequencer feeding a 1-to-4 demux with BURST bits per active channel.
// Optional macro DEMUX_SEQ_MASK_EN enables per-channel masking via en_mask (else all four).
module demux_sel_sequencer #(
    parameter int unsigned BURST = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_sel_sequencer_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] chan_q, chan_d;
    logic [3:0] cnt_q, cnt_d;
    logic       y_q, y_d;
    logic [1:0] s_q, s_d;
    logic       y_valid_q, y_valid_d;
    logic       frame_done_q, frame_done_d;
    logic [3:0] eff_mask;
    logic       xfer;
    logic       last_in_burst;
    logic       has_next;
    logic [1:0] next_chan;
    logic [1:0] first_chan;

    localparam logic [3:0] BurstLast = 4'(BURST - 1);

`ifdef DEMUX_SEQ_MASK_EN
    assign eff_mask = bus.en_mask;
`else
    assign eff_mask = 4'b1111;
`endif

    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Returns {found, index} of the next enabled channel strictly above cur.
    function automatic logic [2:0] next_higher(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first_chan              = lowest_chan(eff_mask);
    assign {has_next, next_chan}   = next_higher(mask_q, chan_q);
    assign xfer                    = (state_q == StRun) && bus.in_valid;
    assign last_in_burst           = (cnt_q == BurstLast);

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        chan_d       = chan_q;
        cnt_d        = cnt_q;
        y_d          = 1'b0;
        s_d          = s_q;
        y_valid_d    = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus.abort && bus.start && (eff_mask != 4'b0000)) begin
                    state_d = StRun;
                    mask_d  = eff_mask;
                    chan_d  = first_chan;
                    cnt_d   = 4'd0;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    y_d       = bus.in_bit;
                    s_d       = chan_q;
                    y_valid_d = 1'b1;
                    if (last_in_burst) begin
                        cnt_d = 4'd0;
                        if (has_next) begin
                            chan_d = next_chan;
                        end else begin
                            frame_done_d = 1'b1;
                            state_d      = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mask_q       <= 4'd0;
            chan_q       <= 2'd0;
            cnt_q        <= 4'd0;
            y_q          <= 1'b0;
            s_q          <= 2'd0;
            y_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            chan_q       <= chan_d;
            cnt_q        <= cnt_d;
            y_q          <= y_d;
            s_q          <= s_d;
            y_valid_q    <= y_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = (state_q == StRun);
    assign bus.busy       = (state_q == StRun);
    assign bus.y          = y_q;
    assign bus.s          = s_q;
    assign bus.y_valid    = y_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed bench for demux_sel_sequencer: full frames, bubbles, masking, abort, reset.
module tb_demux_sel_sequencer;

    localparam int unsigned BURST = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    demux_sel_sequencer_if bus ();

    demux_sel_sequencer #(.BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] eff_of(input logic [3:0] m);
`ifdef DEMUX_SEQ_MASK_EN
        return m;
`else
        return 4'b1111;
`endif
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_y"}, 32'(bus.y), 32'd0);
        check_eq({tag, "_s"}, 32'(bus.s), 32'd0);
        check_eq({tag, "_yv"}, 32'(bus.y_valid), 32'd0);
        check_eq({tag, "_fd"}, 32'(bus.frame_done), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    endtask

    // Starts a frame and streams it; bubbles of nbub idle cycles follow bit index bub_after.
    task automatic run_frame(input string tag, input logic [15:0] bits, input logic [3:0] mask,
                             input int bub_after, input int nbub, input logic start_noise);
        int         chans[$];
        logic [3:0] eff;
        eff = eff_of(mask);
        for (int c = 0; c < 4; c++)
            if (eff[c]) for (int b = 0; b < int'(BURST); b++) chans.push_back(c);

        bus.start   = 1'b1;
        bus.en_mask = mask;
        step();
        bus.start   = start_noise;
        if (chans.size() == 0) begin
            check_eq({tag, "_nostart_busy"}, 32'(bus.busy), 32'd0);
            bus.start = 1'b0;
            return;
        end
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check_eq({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, "_yv0"}, 32'(bus.y_valid), 32'd0);

        for (int i = 0; i < chans.size(); i++) begin
            bus.in_bit   = bits[i];
            bus.in_valid = 1'b1;
            if (start_noise) bus.en_mask = ~mask;
            step();
            check_eq($sformatf("%s_yv%0d", tag, i), 32'(bus.y_valid), 32'd1);
            check_eq($sformatf("%s_y%0d", tag, i), 32'(bus.y), 32'(bits[i]));
            check_eq($sformatf("%s_s%0d", tag, i), 32'(bus.s), 32'(chans[i]));
            check_eq($sformatf("%s_fd%0d", tag, i), 32'(bus.frame_done),
                     32'(i == chans.size() - 1));
            check_eq($sformatf("%s_busy%0d", tag, i), 32'(bus.busy),
                     32'(i != chans.size() - 1));
            if (i == bub_after) begin
                bus.in_valid = 1'b0;
                for (int k = 0; k < nbub; k++) begin
                    step();
                    check_eq($sformatf("%s_bub_yv%0d", tag, k), 32'(bus.y_valid), 32'd0);
                    check_eq($sformatf("%s_bub_y%0d", tag, k), 32'(bus.y), 32'd0);
                    check_eq($sformatf("%s_bub_s%0d", tag, k), 32'(bus.s), 32'(chans[i]));
                end
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check_eq({tag, "_after_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_after_yv"}, 32'(bus.y_valid), 32'd0);
        check_eq({tag, "_after_fd"}, 32'(bus.frame_done), 32'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.en_mask  = 4'b0000;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // Bits 1,0,1,1,0,0,1,1 packed LSB-first.
        run_frame("full", 16'h00CD, 4'b1111, -1, 0, 1'b0);
        run_frame("bubble", 16'h00CD, 4'b1111, 2, 3, 1'b0);
        run_frame("mask1010", 16'h00CD, 4'b1010, -1, 0, 1'b0);
        run_frame("mask0", 16'h00CD, 4'b0000, -1, 0, 1'b0);
        run_frame("startrun", 16'h0036, 4'b1111, -1, 0, 1'b1);

        // Abort on the 5th accepted bit.
        bus.start   = 1'b1;
        bus.en_mask = 4'b1111;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_bit   = 1'b1;
            bus.in_valid = 1'b1;
            step();
        end
        bus.abort = 1'b1;
        step();
        check_eq("abort_yv", 32'(bus.y_valid), 32'd0);
        check_eq("abort_fd", 32'(bus.frame_done), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        // start with abort in IDLE: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        check_eq("abort_start_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        run_frame("post_abort", 16'h00A5, 4'b1111, -1, 0, 1'b0);

        // Asynchronous reset after 3 bits.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_bit   = 1'b1;
            bus.in_valid = 1'b1;
            step();
        end
        check_eq("pre_rst_yv", 32'(bus.y_valid), 32'd1);
        check_eq("pre_rst_s", 32'(bus.s), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_eq("post_rst_fd", 32'(bus.frame_done), 32'd0);
        run_frame("post_rst", 16'h00CD, 4'b1111, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_sel_sequencer.md
# demux_sel_sequencer

Upstream driver for the 1-to-4 gate-level demultiplexer. It accepts a serial bit stream over a valid/ready handshake and produces the demux data bit `y` and select `s[1:0]`. Each channel receives a burst of `BURST` consecutive bits, then the select advances round-robin. After one full pass over the active channels, a `frame_done` strobe is raised and the block returns to idle.

## Interface
Parameters:
- `BURST`, default 2: bits delivered to each channel before the select advances; legal range 1..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a frame when idle; ignored while busy.
- `abort`  in  1  synchronous; ends the current frame immediately.
- `en_mask`  in  4  channel enable mask; bit i enables channel i. Sampled on the accepted `start`.
- `in_bit`  in  1  serial data bit.
- `in_valid`  in  1  `in_bit` is valid.
- `in_ready`  out  1  the block accepts a bit this cycle.
- `y`  out  1  data bit to the demux.
- `s`  out  2  channel select to the demux.
- `y_valid`  out  1  `y`/`s` carry a delivered bit this cycle.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle strobe marking the last bit of a frame.

## Operation
- There are two states, IDLE and RUN.
- IDLE → RUN when `start`=1 and the effective mask is nonzero.
  - The mask is latched into an internal register.
  - The channel register loads the lowest enabled channel.
  - The bit counter clears.
- `start` with an effective mask of 0 is ignored; the block stays in IDLE.
- In RUN, `in_ready`=1. A transfer occurs when `in_valid` & `in_ready`.
- On each transfer:
  - `y` ← `in_bit`, `s` ← current channel, `y_valid` ← 1.
  - The bit counter increments.
  - If the counter was at `BURST`-1, it clears and the channel advances to the next higher enabled channel.
  - If no higher enabled channel exists, the frame ends: `frame_done` ← 1 and the state returns to IDLE.
- With no transfer in a cycle: `y_valid` ← 0 and `y` ← 0, so all demux outputs are low. `s` holds its last value, and the counter and channel hold.
- `abort`=1 in RUN returns the block to IDLE on the next edge.
  - No `frame_done` is raised.
  - A transfer in the same cycle as `abort` is discarded: `y_valid` ← 0.
- `abort` in IDLE has no effect. If `start` and `abort` are both asserted in IDLE, `abort` takes priority and the block stays in IDLE.
- `start` asserted during RUN is ignored, and `en_mask` changes during RUN are ignored.
- Counter width is 4 bits. It never exceeds `BURST`-1.

## Timing
- Reset values: `y`=0, `s`=0, `y_valid`=0, `frame_done`=0, `busy`=0, `in_ready`=0. The state is IDLE, and the counter, channel and latched mask are 0.
- `in_ready` and `busy` are decoded from the state register, with no combinational path from inputs.
- Latency: a bit accepted at edge k appears on `y`/`s` with `y_valid`=1 in the cycle after edge k.
- `frame_done` is asserted in the same cycle as the final `y_valid` of the frame.
- `busy` and `in_ready` fall in that same cycle, so they are 0 in the cycle `frame_done`=1.
- The earliest restart is a `start` sampled in the `frame_done` cycle, which enters RUN on the next edge.
- Frame length is `BURST` × (number of active channels) transfers, with arbitrary `in_valid` bubbles allowed between them.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronously). No `frame_done` is produced.

## Configuration
- Macro `DEMUX_SEQ_MASK_EN`.
- Defined: the effective mask is `en_mask`. Disabled channels are skipped and the frame covers only enabled channels. A `start` with `en_mask`=0 is ignored.
- Undefined: the effective mask is always 4'b1111. `en_mask` is ignored but the port remains, and every frame covers channels 0..3.

## Test plan
- Default config, `BURST`=2, `start` then bits 1,0,1,1,0,0,1,1 with `in_valid` held high → `s` = 0,0,1,1,2,2,3,3 and `y` = 1,0,1,1,0,0,1,1 on consecutive `y_valid` cycles, each one cycle after acceptance. `frame_done`=1 with the 8th bit, and `busy`=0 in that same cycle.
- Bubbles: as above, but `in_valid`=0 for 3 cycles after the 3rd bit → `y_valid`=0 and `y`=0 for 3 cycles, `s` holds 1. The sequence resumes with `s`=1, then 2.
- `DEMUX_SEQ_MASK_EN` defined, `en_mask`=4'b1010, `BURST`=2, 4 bits → `s` = 1,1,3,3 and `frame_done` on the 4th bit. The same stimulus with the macro undefined → 8-bit frame over `s`=0..3.
- Abort: assert `abort` in the cycle the 5th bit is accepted → no `y_valid` for that bit and no `frame_done`. The block is in IDLE next cycle, and a new `start` begins again at channel 0.
- Reset mid-frame after 3 bits → all outputs read 0 immediately. After `rst_n` is released, `start` begins a frame at `s`=0 with the counter at 0.
- `DEMUX_SEQ_MASK_EN` defined, `start` with `en_mask`=0 → `busy` stays 0. Also, `start` asserted during RUN → no effect on the ongoing frame.
